// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch (IF) and data (D) ports.
// Each access: grant edge -> MEM_LAT ACCESS cycles -> one RESP cycle carrying the valid pulse.
module mem_port_arbiter #(
  parameter int ADDR_W    = 64,
  parameter int DATA_W    = 64,
  parameter int MEM_LAT   = 2,
  parameter int DATA_PRIO = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_xfer_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_xfer_size,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int              CNT_W      = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_LAT - 1);
  localparam logic [3:0]      FETCH_SIZE = 4'b0100;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             grant_d;
  logic             last_d;
  logic             store;
  logic             pick_any;
  logic             pick_d;

  // In RESP the port just served is ignored so the other one gets the next slot.
  always_comb begin
    pick_any = 1'b0;
    pick_d   = 1'b0;
    case (state)
      IDLE: begin
        pick_any = if_req | d_req;
        pick_d   = d_req & (~if_req | (DATA_PRIO != 0) | ~last_d);
      end
      RESP: begin
        pick_any = grant_d ? if_req : d_req;
        pick_d   = ~grant_d;
      end
      default: begin
        pick_any = 1'b0;
        pick_d   = 1'b0;
      end
    endcase
  end

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = d_req & ~d_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      grant_d       <= 1'b0;
      last_d        <= 1'b1;
      store         <= 1'b0;
      if_rdata      <= '0;
      if_valid      <= 1'b0;
      d_rdata       <= '0;
      d_valid       <= 1'b0;
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_xfer_size <= '0;
    end else begin
      if_valid <= 1'b0;
      d_valid  <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (pick_any) begin
            state         <= ACCESS;
            cnt           <= '0;
            grant_d       <= pick_d;
            last_d        <= pick_d;
            store         <= pick_d & d_we;
            mem_en        <= 1'b1;
            // With a single-cycle memory the first ACCESS cycle is also the write cycle.
            mem_we        <= pick_d & d_we & (CNT_LAST == '0);
            mem_addr      <= pick_d ? d_addr : if_addr;
            mem_wdata     <= pick_d ? d_wdata : '0;
            mem_xfer_size <= pick_d ? d_xfer_size : FETCH_SIZE;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            state  <= RESP;
            cnt    <= '0;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
            if (grant_d) begin
              d_valid <= 1'b1;
              d_rdata <= store ? '0 : mem_rdata;
            end else begin
              if_valid <= 1'b1;
              if_rdata <= mem_rdata[31:0];
            end
          end else begin
            cnt    <= cnt + 1'b1;
            mem_we <= store & ((cnt + 1'b1) == CNT_LAST);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: dut_a uses data priority, dut_b uses round-robin; valid pulses are scored against queues.
module tb_mem_port_arbiter;

  typedef struct packed {
    logic        is_d;
    logic [63:0] data;
  } exp_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [63:0] data;
  } wr_t;

  logic clk;
  logic rst;

  logic        if_req_a, d_req_a, d_we_a;
  logic [63:0] if_addr_a, d_addr_a, d_wdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic [31:0] if_rdata_a;
  logic [3:0]  d_xfer_size_a, mem_xfer_size_a;
  logic        if_valid_a, if_stall_a, d_valid_a, d_stall_a, mem_en_a, mem_we_a;

  logic        if_req_b, d_req_b, d_we_b;
  logic [63:0] if_addr_b, d_addr_b, d_wdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
  logic [31:0] if_rdata_b;
  logic [3:0]  d_xfer_size_b, mem_xfer_size_b;
  logic        if_valid_b, if_stall_b, d_valid_b, d_stall_b, mem_en_b, mem_we_b;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_a[$];
  exp_t sb_b[$];
  wr_t  wr_a[$];
  exp_t e_a, e_b;
  wr_t  w_a;
  logic [63:0] t;
  int   nv;
  int   vc[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] rd_fn(input logic [63:0] addr);
    if (addr == 64'h10) return 64'h0000_0000_8B02_0041;
    return {addr[31:0] ^ 32'h5A5A_0000, ~addr[31:0]};
  endfunction

  assign mem_rdata_a = mem_en_a ? rd_fn(mem_addr_a) : 64'h0;
  assign mem_rdata_b = mem_en_b ? rd_fn(mem_addr_b) : 64'h0;

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .DATA_PRIO(1)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req_a), .if_addr(if_addr_a), .if_rdata(if_rdata_a),
    .if_valid(if_valid_a), .if_stall(if_stall_a),
    .d_req(d_req_a), .d_we(d_we_a), .d_addr(d_addr_a), .d_wdata(d_wdata_a),
    .d_xfer_size(d_xfer_size_a), .d_rdata(d_rdata_a), .d_valid(d_valid_a), .d_stall(d_stall_a),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
    .mem_xfer_size(mem_xfer_size_a), .mem_rdata(mem_rdata_a)
  );

  mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .MEM_LAT(2), .DATA_PRIO(0)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req_b), .if_addr(if_addr_b), .if_rdata(if_rdata_b),
    .if_valid(if_valid_b), .if_stall(if_stall_b),
    .d_req(d_req_b), .d_we(d_we_b), .d_addr(d_addr_b), .d_wdata(d_wdata_b),
    .d_xfer_size(d_xfer_size_b), .d_rdata(d_rdata_b), .d_valid(d_valid_b), .d_stall(d_stall_b),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
    .mem_xfer_size(mem_xfer_size_b), .mem_rdata(mem_rdata_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic is_d, input logic [63:0] data);
    exp_t x;
    x.is_d = is_d;
    x.data = data;
    sb_a.push_back(x);
  endtask

  task automatic push_b(input logic is_d, input logic [63:0] data);
    exp_t x;
    x.is_d = is_d;
    x.data = data;
    sb_b.push_back(x);
  endtask

  task automatic push_wr(input logic [63:0] addr, input logic [63:0] data);
    wr_t x;
    x.addr = addr;
    x.data = data;
    wr_a.push_back(x);
  endtask

  always @(negedge clk) begin
    if (rst && (if_valid_a || d_valid_a)) begin
      if (sb_a.size() == 0) begin
        check("a_unexpected_valid", {62'b0, if_valid_a, d_valid_a}, 64'h0);
      end else begin
        e_a = sb_a.pop_front();
        check("a_valid_port", {63'b0, d_valid_a}, {63'b0, e_a.is_d});
        check("a_valid_data", d_valid_a ? d_rdata_a : {32'b0, if_rdata_a}, e_a.data);
      end
    end
    if (rst && mem_we_a) begin
      if (wr_a.size() == 0) begin
        check("a_unexpected_write", {63'b0, mem_we_a}, 64'h0);
      end else begin
        w_a = wr_a.pop_front();
        check("a_write_addr", mem_addr_a, w_a.addr);
        check("a_write_data", mem_wdata_a, w_a.data);
      end
    end
    if (rst && (if_valid_b || d_valid_b)) begin
      if (sb_b.size() == 0) begin
        check("b_unexpected_valid", {62'b0, if_valid_b, d_valid_b}, 64'h0);
      end else begin
        e_b = sb_b.pop_front();
        check("b_valid_port", {63'b0, d_valid_b}, {63'b0, e_b.is_d});
        check("b_valid_data", d_valid_b ? d_rdata_b : {32'b0, if_rdata_b}, e_b.data);
      end
    end
  end

  initial begin
    rst = 1'b0;
    if_req_a = 1'b0; if_addr_a = '0; d_req_a = 1'b0; d_we_a = 1'b0;
    d_addr_a = '0; d_wdata_a = '0; d_xfer_size_a = 4'b1000;
    if_req_b = 1'b1; if_addr_b = 64'h100; d_req_b = 1'b1; d_we_b = 1'b0;
    d_addr_b = 64'h200; d_wdata_b = '0; d_xfer_size_b = 4'b1000;

    // Round-robin: IF wins first because last_grant resets to D.
    t = rd_fn(64'h100);
    push_b(1'b0, {32'b0, t[31:0]});
    push_b(1'b1, rd_fn(64'h200));
    push_b(1'b0, {32'b0, t[31:0]});
    push_b(1'b1, rd_fn(64'h200));

    repeat (3) step();
    check("rst_mem_en", {63'b0, mem_en_a}, 64'h0);
    check("rst_mem_we", {63'b0, mem_we_a}, 64'h0);
    check("rst_if_valid", {63'b0, if_valid_a}, 64'h0);
    check("rst_d_valid", {63'b0, d_valid_a}, 64'h0);
    check("rst_mem_addr", mem_addr_a, 64'h0);
    check("rst_mem_size", {60'b0, mem_xfer_size_a}, 64'h0);
    check("rst_d_rdata", d_rdata_a, 64'h0);
    check("rst_if_stall", {63'b0, if_stall_a}, 64'h0);
    check("rst_b_mem_en", {63'b0, mem_en_b}, 64'h0);
    check("rst_b_if_stall", {63'b0, if_stall_b}, 64'h1);
    rst = 1'b1;

    nv = 0;
    for (int c = 1; c <= 30 && nv < 4; c++) begin
      step();
      if (if_valid_b || d_valid_b) begin
        vc[nv] = c;
        nv++;
      end
    end
    check("rr_valid_count", 64'(nv), 64'd4);
    check("rr_first_valid", 64'(vc[0]), 64'd3);
    check("rr_gap1", 64'(vc[1] - vc[0]), 64'd3);
    check("rr_gap2", 64'(vc[2] - vc[1]), 64'd3);
    check("rr_gap3", 64'(vc[3] - vc[2]), 64'd3);
    if_req_b = 1'b0;
    d_req_b  = 1'b0;
    step();
    check("rr_idle_after", {63'b0, mem_en_b}, 64'h0);

    // Single fetch.
    if_req_a = 1'b1; if_addr_a = 64'h10;
    push_a(1'b0, 64'h8B02_0041);
    #1;
    check("f_stall_idle", {63'b0, if_stall_a}, 64'h1);
    step();
    check("f_acc1_en", {63'b0, mem_en_a}, 64'h1);
    check("f_acc1_addr", mem_addr_a, 64'h10);
    check("f_acc1_size", {60'b0, mem_xfer_size_a}, 64'h4);
    check("f_acc1_stall", {63'b0, if_stall_a}, 64'h1);
    step();
    check("f_acc2_en", {63'b0, mem_en_a}, 64'h1);
    check("f_acc2_valid", {63'b0, if_valid_a}, 64'h0);
    step();
    check("f_resp_valid", {63'b0, if_valid_a}, 64'h1);
    check("f_resp_rdata", {32'b0, if_rdata_a}, 64'h8B02_0041);
    check("f_resp_en", {63'b0, mem_en_a}, 64'h0);
    check("f_resp_stall", {63'b0, if_stall_a}, 64'h0);
    if_req_a = 1'b0;
    step();
    check("f_after_valid", {63'b0, if_valid_a}, 64'h0);
    check("f_rdata_hold", {32'b0, if_rdata_a}, 64'h8B02_0041);

    // Store: one write cycle, d_rdata reads back as zero.
    d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 64'h40; d_wdata_a = 64'hDEAD_BEEF; d_xfer_size_a = 4'b1000;
    push_a(1'b1, 64'h0);
    push_wr(64'h40, 64'hDEAD_BEEF);
    step();
    check("s_acc1_we", {63'b0, mem_we_a}, 64'h0);
    check("s_acc1_size", {60'b0, mem_xfer_size_a}, 64'h8);
    check("s_acc1_stall", {63'b0, d_stall_a}, 64'h1);
    step();
    check("s_acc2_we", {63'b0, mem_we_a}, 64'h1);
    step();
    check("s_resp_we", {63'b0, mem_we_a}, 64'h0);
    check("s_resp_dvalid", {63'b0, d_valid_a}, 64'h1);
    check("s_resp_drdata", d_rdata_a, 64'h0);
    check("s_resp_ifvalid", {63'b0, if_valid_a}, 64'h0);
    d_req_a = 1'b0; d_we_a = 1'b0;
    step();

    // Tie under data priority: D load first, fetch granted in D's RESP.
    if_req_a = 1'b1; if_addr_a = 64'h20;
    d_req_a = 1'b1; d_we_a = 1'b0; d_addr_a = 64'h80;
    push_a(1'b1, rd_fn(64'h80));
    t = rd_fn(64'h20);
    push_a(1'b0, {32'b0, t[31:0]});
    step();
    check("t_acc1_addr", mem_addr_a, 64'h80);
    step();
    step();
    check("t_d_valid", {63'b0, d_valid_a}, 64'h1);
    check("t_d_rdata", d_rdata_a, rd_fn(64'h80));
    check("t_if_wait", {63'b0, if_valid_a}, 64'h0);
    d_req_a = 1'b0;
    step();
    check("t_if_granted", {63'b0, mem_en_a}, 64'h1);
    check("t_if_addr", mem_addr_a, 64'h20);
    step();
    step();
    check("t_if_valid", {63'b0, if_valid_a}, 64'h1);
    check("t_d_rdata_hold", d_rdata_a, rd_fn(64'h80));
    if_req_a = 1'b0;
    step();

    // Fetch held across valid: each new fetch restarts from IDLE.
    if_req_a = 1'b1; if_addr_a = 64'h30;
    t = rd_fn(64'h30);
    for (int i = 0; i < 3; i++) push_a(1'b0, {32'b0, t[31:0]});
    nv = 0;
    for (int c = 1; c <= 30 && nv < 3; c++) begin
      step();
      if (if_valid_a) begin
        vc[nv] = c;
        nv++;
        if (nv == 3) if_req_a = 1'b0;
      end
    end
    check("h_valid_count", 64'(nv), 64'd3);
    check("h_first_valid", 64'(vc[0]), 64'd3);
    check("h_gap1", 64'(vc[1] - vc[0]), 64'd4);
    check("h_gap2", 64'(vc[2] - vc[1]), 64'd4);
    step();

    // Reset during a store abandons it; the held request restarts afterwards.
    d_req_a = 1'b1; d_we_a = 1'b1; d_addr_a = 64'h48; d_wdata_a = 64'h1234;
    push_a(1'b1, 64'h0);
    push_wr(64'h48, 64'h1234);
    step();
    check("r_acc1_en", {63'b0, mem_en_a}, 64'h1);
    #2;
    rst = 1'b0;
    #1;
    check("r_async_en", {63'b0, mem_en_a}, 64'h0);
    check("r_async_we", {63'b0, mem_we_a}, 64'h0);
    step();
    check("r_no_dvalid", {63'b0, d_valid_a}, 64'h0);
    rst = 1'b1;
    step();
    check("r_restart_en", {63'b0, mem_en_a}, 64'h1);
    check("r_restart_we1", {63'b0, mem_we_a}, 64'h0);
    step();
    check("r_restart_we2", {63'b0, mem_we_a}, 64'h1);
    step();
    check("r_restart_dvalid", {63'b0, d_valid_a}, 64'h1);
    d_req_a = 1'b0; d_we_a = 1'b0;
    repeat (3) step();

    check("a_scoreboard_empty", 64'(sb_a.size()), 64'd0);
    check("a_writes_empty", 64'(wr_a.size()), 64'd0);
    check("b_scoreboard_empty", 64'(sb_b.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
